// File: rtl/vga_pkg.sv
// Shared VGA timing types, default 640x480@60 timing
// and a helper for the per-axis total.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    function automatic int timing_total(vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with sync/active flags
// registered from the next count so they align with cnt.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACTIVE = 640,
    parameter int   FP     = 16,
    parameter int   SYNC   = 96,
    parameter int   BP     = 48,
    parameter logic POL    = 1'b0,
    parameter int   CW     = 10
) (
    input  logic          vgaclk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          sync,
    output logic          active
);

    localparam vga_timing_t T = '{
        active: ACTIVE, fp: FP, sync: SYNC, bp: BP
    };
    localparam int TOT = timing_total(T);

    // One extra bit so segment ends equal to 2**CW still compare
    localparam logic [CW:0] LAST    = (CW+1)'(TOT - 1);
    localparam logic [CW:0] S_BEG   = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0] S_END   = (CW+1)'(ACTIVE + FP + SYNC);
    localparam logic [CW:0] ACT_END = (CW+1)'(ACTIVE);

    logic [CW-1:0] nxt;
    logic [CW:0]   nxt_w;

    always_comb begin
        wrap  = inc && ({1'b0, cnt} == LAST);
        nxt   = cnt;
        if (wrap)
            nxt = '0;
        else if (inc)
            nxt = cnt + CW'(1);
        nxt_w = {1'b0, nxt};
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            cnt    <= '0;
            sync   <= ~POL;
            active <= 1'b1;
        end else begin
            cnt    <= nxt;
            sync   <= (nxt_w >= S_BEG && nxt_w < S_END) ? POL : ~POL;
            active <= nxt_w < ACT_END;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: x/y counters, syncs,
// data enable, line/frame start flags and frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 10,
    parameter int   FW        = 8
) (
    input  logic          vgaclk,
    input  logic          reset,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sol,
    output logic          sof,
    output logic [FW-1:0] frame_cnt
);

    localparam vga_timing_t HT = '{
        active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP
    };
    localparam vga_timing_t VT = '{
        active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP
    };
    localparam int H_TOT = timing_total(HT);
    localparam int V_TOT = timing_total(VT);

    if (H_TOT > (1 << CW) || V_TOT > (1 << CW) ||
        H_ACTIVE == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_SYNC == 0 || V_BP == 0 ||
        CW == 0 || FW == 0) begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: invalid timing parameters");
    end

    logic h_wrap;
    logic v_wrap;
    logic h_act;
    logic v_act;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(HSYNC_POL), .CW(CW)
    ) u_h (
        .vgaclk(vgaclk),
        .reset (reset),
        .inc   (en),
        .cnt   (x),
        .wrap  (h_wrap),
        .sync  (hsync),
        .active(h_act)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(VSYNC_POL), .CW(CW)
    ) u_v (
        .vgaclk(vgaclk),
        .reset (reset),
        .inc   (h_wrap),
        .cnt   (y),
        .wrap  (v_wrap),
        .sync  (vsync),
        .active(v_act)
    );

    assign de = h_act & v_act;

    // A wrap this cycle is exactly when the next position is x==0 / (0,0)
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            sol       <= 1'b1;
            sof       <= 1'b1;
            frame_cnt <= '0;
        end else if (en) begin
            sol <= h_wrap;
            sof <= v_wrap;
            if (v_wrap)
                frame_cnt <= frame_cnt + FW'(1);
        end
    end

endmodule
